unidade_adiantamento: RTL and testbench
=======================================

Name: unidade_adiantamento

Overview:
Forwarding and load-use hazard unit for the 5-stage MIPS pipeline. It tracks the destination register and write/load flags of the instructions in the ID/EX, EX/MEM and MEM/WB stages. It drives the 2-bit selects of the two operand Mux3 instances in front of the ALU. It also raises a one-cycle stall request to PC/IF-ID on a load-use dependency, and counts stall cycles for debug.

Parameters:
LARGURA_REG, 5, register index width
LARGURA_CONTADOR, 16, stall counter width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
avanca  in  1  pipeline advances this cycle (0 = global hold, e.g. memory wait)
descarta  in  1  kill the instruction currently in ID (taken branch/jump)
id_rs  in  LARGURA_REG  rs of the instruction in ID
id_rt  in  LARGURA_REG  rt of the instruction in ID
id_usa_rt  in  1  instruction in ID reads rt as a source
id_destino  in  LARGURA_REG  destination register of the instruction in ID
id_escreve  in  1  instruction in ID writes the register file
id_carga  in  1  instruction in ID is a load
selecao_a  out  2  select for the operand-A Mux3
selecao_b  out  2  select for the operand-B Mux3
parada  out  1  load-use stall request
contador_paradas  out  LARGURA_CONTADOR  saturating count of stall cycles

Behaviour:
- Internal stage registers:
  - EX: rs, rt, destino, escreve, carga
  - MEM: destino, escreve, carga
  - WB: destino, escreve
- Bubble = all fields 0.
- Reset (reset_n=0, asynchronous, effective immediately including mid-operation):
  - All stage registers become bubbles and contador_paradas=0.
  - Hence selecao_a=selecao_b=00 and parada=0 while reset is held.
- Rising edge with avanca=1:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble if (parada or descarta), else the ID fields.
- Rising edge with avanca=0: all stage registers and the counter hold.
- Select encoding, matching the Mux3 inputs:
  - 00 = register file value (entrada1)
  - 01 = MEM/WB writeback value (entrada2)
  - 10 = EX/MEM ALU result (entrada3)
  - 11 is never driven.
- selecao_a is combinational from the stage registers:
  - 10 if MEM.escreve & !MEM.carga & MEM.destino!=0 & MEM.destino==EX.rs
  - else 01 if WB.escreve & WB.destino!=0 & WB.destino==EX.rs
  - else 00.
  - EX/MEM (the younger producer) has priority over MEM/WB.
- selecao_b: identical rule using EX.rt.
- Register 0 is never forwarded.
- Load entries in MEM are never forwarded with 10. The stall guarantees the consumer instead sees the load in WB and gets 01.
- parada (combinational):
  - 1 when EX.carga & EX.escreve & EX.destino!=0 & (EX.destino==id_rs | (id_usa_rt & EX.destino==id_rt)) & !descarta.
  - descarta has priority over parada: a killed instruction never stalls.
- parada does not depend on avanca. With avanca=0 everything holds anyway.
- Stall sequence:
  - Cycle with parada=1 and avanca=1: a bubble enters EX and the instruction in ID is held by the external IF/ID logic.
  - Next cycle: the load is in MEM and the bubble in EX, so parada=0.
  - The following cycle: the consumer is in EX and the load in WB, so its select is 01.
- contador_paradas increments on each edge where parada=1 and avanca=1. It saturates at all-ones and never wraps.

Test Plan:
1. Back-to-back ALU, distance 1: add r8 then sub rs=r8 -> selecao_a=10 in the consumer's EX cycle, selecao_b=00.
2. Distance 2 and priority:
   - add r8; nop; or rt=r8 with id_usa_rt=1 -> selecao_b=01.
   - Writes to r8 in both MEM and WB -> selecao_b=10.
3. Register 0: producer id_destino=0, id_escreve=1; consumer rs=0 -> selecao_a=00, parada=0.
4. Load-use:
   - lw r9 then consumer rt=r9, id_usa_rt=1 -> parada=1 for exactly one cycle, bubble in EX, then selecao_b=01, contador_paradas=1.
   - Same with id_usa_rt=0 -> parada never 1.
5. Hold and saturation:
   - avanca=0 for 3 cycles mid-sequence -> selecao_a/selecao_b/parada constant, counter unchanged.
   - With LARGURA_CONTADOR=2, 5 stalls -> contador_paradas=3.
6. Kill and reset:
   - Load-use condition with descarta=1 -> parada=0 and a bubble enters EX.
   - Assert reset_n=0 between clock edges -> selecao_a, selecao_b, parada and contador_paradas all 0 immediately.

Source files
------------

// File: rtl/unidade_adiantamento.sv
// rtl/unidade_adiantamento.sv - forwarding and load-use hazard unit for the 5-stage MIPS pipeline
module unidade_adiantamento #(
  parameter int LARGURA_REG      = 5,
  parameter int LARGURA_CONTADOR = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        avanca,
  input  logic                        descarta,
  input  logic [LARGURA_REG-1:0]      id_rs,
  input  logic [LARGURA_REG-1:0]      id_rt,
  input  logic                        id_usa_rt,
  input  logic [LARGURA_REG-1:0]      id_destino,
  input  logic                        id_escreve,
  input  logic                        id_carga,
  output logic [1:0]                  selecao_a,
  output logic [1:0]                  selecao_b,
  output logic                        parada,
  output logic [LARGURA_CONTADOR-1:0] contador_paradas
);

  localparam logic [1:0] SEL_REGS = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;

  logic [LARGURA_REG-1:0]      ex_rs_q, ex_rt_q, ex_destino_q;
  logic                        ex_escreve_q, ex_carga_q;
  logic [LARGURA_REG-1:0]      mem_destino_q;
  logic                        mem_escreve_q, mem_carga_q;
  logic [LARGURA_REG-1:0]      wb_destino_q;
  logic                        wb_escreve_q;
  logic [LARGURA_CONTADOR-1:0] contador_q, contador_d;
  logic                        bolha;
  logic                        mem_encaminha, wb_encaminha;

  // A load in MEM has no value yet; only ALU results may be bypassed from there.
  assign mem_encaminha = mem_escreve_q && !mem_carga_q && (mem_destino_q != '0);
  assign wb_encaminha  = wb_escreve_q && (wb_destino_q != '0);

  always_comb begin
    selecao_a = SEL_REGS;
    if (mem_encaminha && (mem_destino_q == ex_rs_q)) begin
      selecao_a = SEL_MEM;
    end else if (wb_encaminha && (wb_destino_q == ex_rs_q)) begin
      selecao_a = SEL_WB;
    end
  end

  always_comb begin
    selecao_b = SEL_REGS;
    if (mem_encaminha && (mem_destino_q == ex_rt_q)) begin
      selecao_b = SEL_MEM;
    end else if (wb_encaminha && (wb_destino_q == ex_rt_q)) begin
      selecao_b = SEL_WB;
    end
  end

  always_comb begin
    parada = 1'b0;
    if (ex_carga_q && ex_escreve_q && (ex_destino_q != '0) && !descarta) begin
      parada = (ex_destino_q == id_rs) || (id_usa_rt && (ex_destino_q == id_rt));
    end
  end

  assign bolha = parada || descarta;

  always_comb begin
    contador_d = contador_q;
    if (parada && (contador_q != {LARGURA_CONTADOR{1'b1}})) begin
      contador_d = contador_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_destino_q  <= '0;
      ex_escreve_q  <= 1'b0;
      ex_carga_q    <= 1'b0;
      mem_destino_q <= '0;
      mem_escreve_q <= 1'b0;
      mem_carga_q   <= 1'b0;
      wb_destino_q  <= '0;
      wb_escreve_q  <= 1'b0;
      contador_q    <= '0;
    end else if (avanca) begin
      wb_destino_q  <= mem_destino_q;
      wb_escreve_q  <= mem_escreve_q;
      mem_destino_q <= ex_destino_q;
      mem_escreve_q <= ex_escreve_q;
      mem_carga_q   <= ex_carga_q;
      if (bolha) begin
        ex_rs_q      <= '0;
        ex_rt_q      <= '0;
        ex_destino_q <= '0;
        ex_escreve_q <= 1'b0;
        ex_carga_q   <= 1'b0;
      end else begin
        ex_rs_q      <= id_rs;
        ex_rt_q      <= id_rt;
        ex_destino_q <= id_destino;
        ex_escreve_q <= id_escreve;
        ex_carga_q   <= id_carga;
      end
      contador_q <= contador_d;
    end
  end

  assign contador_paradas = contador_q;

endmodule

// File: tb/tb_unidade_adiantamento.sv
// tb/tb_unidade_adiantamento.sv - scoreboard bench for unidade_adiantamento
module tb_unidade_adiantamento;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        avanca = 1'b0;
  logic        descarta = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_destino = '0;
  logic        id_usa_rt = 1'b0, id_escreve = 1'b0, id_carga = 1'b0;
  logic [1:0]  selecao_a, selecao_b, sat_sel_a, sat_sel_b;
  logic        parada, sat_parada;
  logic [15:0] contador_paradas;
  logic [1:0]  sat_contador;

  unidade_adiantamento u_dut (
    .clock(clock), .reset_n(reset_n), .avanca(avanca), .descarta(descarta),
    .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt), .id_destino(id_destino),
    .id_escreve(id_escreve), .id_carga(id_carga),
    .selecao_a(selecao_a), .selecao_b(selecao_b), .parada(parada),
    .contador_paradas(contador_paradas)
  );

  unidade_adiantamento #(.LARGURA_CONTADOR(2)) u_sat (
    .clock(clock), .reset_n(reset_n), .avanca(avanca), .descarta(descarta),
    .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt), .id_destino(id_destino),
    .id_escreve(id_escreve), .id_carga(id_carga),
    .selecao_a(sat_sel_a), .selecao_b(sat_sel_b), .parada(sat_parada),
    .contador_paradas(sat_contador)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs, rt, dest;
    logic       wr, ld;
  } ins_t;

  typedef struct packed {
    logic [1:0]  sa, sb;
    logic        p;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  ins_t pipe [3];
  int   cnt, cnt2;
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic bit m_stall();
    ins_t ex = pipe[0];
    if (!ex.ld || !ex.wr || ex.dest == 0 || descarta) return 1'b0;
    return (ex.dest == id_rs) || (id_usa_rt && ex.dest == id_rt);
  endfunction

  // Youngest producer holding a usable value wins; loads in MEM are skipped.
  function automatic logic [1:0] m_sel(input logic [4:0] r);
    if (r == 0) return 2'd0;
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].wr && pipe[k].dest == r && !(k == 1 && pipe[k].ld))
        return (k == 1) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    cnt = 0;
    cnt2 = 0;
  endtask

  task automatic model_edge();
    bit st;
    if (!reset_n || !avanca) return;
    st = m_stall();
    if (st) begin
      if (cnt < 65535) cnt++;
      if (cnt2 < 3) cnt2++;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (st || descarta) ? ins_t'(0) : ins_t'{id_rs, id_rt, id_destino, id_escreve, id_carga};
  endtask

  task automatic step(input bit r, input bit av, input bit de,
                      input logic [4:0] rs, input logic [4:0] rt, input bit usa,
                      input logic [4:0] dst, input bit wr, input bit ld);
    exp_t e;
    @(posedge clock);
    #1;
    model_edge();
    reset_n = r;
    if (!r) model_clear();
    avanca = av; descarta = de;
    id_rs = rs; id_rt = rt; id_usa_rt = usa;
    id_destino = dst; id_escreve = wr; id_carga = ld;
    e.sa = m_sel(pipe[0].rs);
    e.sb = m_sel(pipe[0].rt);
    e.p  = m_stall();
    e.c  = 16'(cnt);
    e.c2 = 2'(cnt2);
    sb_q.push_back(e);
  endtask

  task automatic nop();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (selecao_a !== e.sa) begin
        n_err++; $display("FAIL selecao_a t=%0t got %b exp %b", $time, selecao_a, e.sa);
      end
      if (selecao_b !== e.sb) begin
        n_err++; $display("FAIL selecao_b t=%0t got %b exp %b", $time, selecao_b, e.sb);
      end
      if (parada !== e.p) begin
        n_err++; $display("FAIL parada t=%0t got %b exp %b", $time, parada, e.p);
      end
      if (contador_paradas !== e.c) begin
        n_err++; $display("FAIL contador t=%0t got %0d exp %0d", $time, contador_paradas, e.c);
      end
      if (sat_contador !== e.c2) begin
        n_err++; $display("FAIL contador_sat t=%0t got %0d exp %0d", $time, sat_contador, e.c2);
      end
    end
  end

  initial begin
    model_clear();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8, 8, 1, 8, 1, 1);
    nop();
    // distance-1 ALU forward on rs
    step(1, 1, 0, 1, 2, 1, 8, 1, 0);
    step(1, 1, 0, 8, 9, 1, 10, 1, 0);
    nop(); nop();
    // distance-2 forward on rt, then MEM-over-WB priority
    step(1, 1, 0, 1, 2, 1, 8, 1, 0);
    nop();
    step(1, 1, 0, 1, 8, 1, 11, 1, 0);
    step(1, 1, 0, 1, 2, 1, 8, 1, 0);
    step(1, 1, 0, 3, 4, 1, 8, 1, 0);
    step(1, 1, 0, 5, 8, 1, 12, 1, 0);
    nop(); nop();
    // register 0 never forwarded
    step(1, 1, 0, 1, 2, 1, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1, 13, 1, 0);
    nop(); nop();
    // load-use on rt, with and without id_usa_rt
    step(1, 1, 0, 1, 2, 0, 9, 1, 1);
    step(1, 1, 0, 4, 9, 1, 14, 1, 0);
    step(1, 1, 0, 4, 9, 1, 14, 1, 0);
    nop(); nop();
    step(1, 1, 0, 1, 2, 0, 9, 1, 1);
    step(1, 1, 0, 4, 9, 0, 14, 1, 0);
    nop(); nop();
    // hold for 3 cycles during a stall, repeated to saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 1, 2, 0, 9, 1, 1);
      step(1, 1, 0, 9, 3, 1, 15, 1, 0);
      if (i == 0) repeat (3) step(1, 0, 0, 9, 3, 1, 15, 1, 0);
      step(1, 1, 0, 9, 3, 1, 15, 1, 0);
      nop();
    end
    // kill wins over load-use
    step(1, 1, 0, 1, 2, 0, 9, 1, 1);
    step(1, 1, 1, 9, 9, 1, 16, 1, 0);
    nop(); nop();
    // asynchronous reset in mid-stall
    step(1, 1, 0, 1, 2, 0, 9, 1, 1);
    step(1, 1, 0, 9, 2, 1, 17, 1, 0);
    step(0, 1, 0, 9, 2, 1, 17, 1, 0);
    step(1, 1, 0, 9, 2, 1, 17, 1, 0);
    nop();
    for (int i = 0; i < 2000; i++) begin
      step(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
      if ($urandom_range(0, 199) == 0) step(0, 1, 0, 1, 1, 1, 1, 1, 1);
    end
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
